// File: rtl/ahb_rdata_aligner_pkg.sv
// ----------------------------------------------------------------------------
// ahb_align_pkg
// Shared AHB encodings for the read-data aligner and the byte-lane mask helper.
//   htrans_e  : HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ)
//   hsize_e   : HSIZE encodings (byte .. 1024-bit)
//   lane_mask : per-byte enable for a transfer of 2**size bytes starting at
//               byte lane 'off' on a bus that is 'nbyte' lanes wide
// ----------------------------------------------------------------------------
package ahb_align_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE   = 3'd0,
        HSIZE_HALF   = 3'd1,
        HSIZE_WORD   = 3'd2,
        HSIZE_DWORD  = 3'd3,
        HSIZE_4WORD  = 3'd4,
        HSIZE_8WORD  = 3'd5,
        HSIZE_16WORD = 3'd6,
        HSIZE_32WORD = 3'd7
    } hsize_e;

    // Widest bus this block supports (64-bit data).
    localparam int MAX_NBYTE = 8;

    function automatic logic [MAX_NBYTE-1:0] lane_mask(
        input logic [2:0] size,
        input logic [2:0] off,
        input int         nbyte
    );
        logic [MAX_NBYTE-1:0] m;
        int                   bytes;
        bytes = 1 << size;
        m     = '0;
        for (int i = 0; i < MAX_NBYTE; i++) begin
            m[i] = (i >= int'(off)) && (i < int'(off) + bytes) && (i < nbyte);
        end
        return m;
    endfunction

endpackage

// File: rtl/ahb_rdata_aligner_if.sv
// ----------------------------------------------------------------------------
// ahb_rdata_aligner_if
// Bus-side bundle of the read-data aligner.
//   slave  modport : view of the aligner (bus inputs in, aligned data/status out)
//   master modport : view of whoever drives the bus signals (e.g. a bench)
// Signals: mst_htrans/hwrite/hsize/haddr, pad_biu_bigend_b, slv_hready,
//          slv_hresp, slv_hrdata (in); mst_hrdata, rd_pend, size_err,
//          err_cnt (out).
// ----------------------------------------------------------------------------
interface ahb_rdata_aligner_if #(
    parameter int DATA_W = 32
);
    localparam int AW = $clog2(DATA_W / 8);

    logic [1:0]        mst_htrans;
    logic              mst_hwrite;
    logic [2:0]        mst_hsize;
    logic [AW-1:0]     mst_haddr;
    logic              pad_biu_bigend_b;
    logic              slv_hready;
    logic              slv_hresp;
    logic [DATA_W-1:0] slv_hrdata;
    logic [DATA_W-1:0] mst_hrdata;
    logic              rd_pend;
    logic              size_err;
    logic [15:0]       err_cnt;

    modport slave (
        input  mst_htrans, mst_hwrite, mst_hsize, mst_haddr, pad_biu_bigend_b,
        input  slv_hready, slv_hresp, slv_hrdata,
        output mst_hrdata, rd_pend, size_err, err_cnt
    );

    modport master (
        output mst_htrans, mst_hwrite, mst_hsize, mst_haddr, pad_biu_bigend_b,
        output slv_hready, slv_hresp, slv_hrdata,
        input  mst_hrdata, rd_pend, size_err, err_cnt
    );

endinterface

// File: rtl/ahb_rdata_aligner_lane_mask.sv
// ----------------------------------------------------------------------------
// ahb_lane_mask
// Combinational byte-lane enable generator.
//   size    : HSIZE of the transfer
//   off     : first byte lane of the transfer
//   lane_en : one enable per byte lane of an NBYTE-lane bus
// ----------------------------------------------------------------------------
module ahb_lane_mask
    import ahb_align_pkg::*;
#(
    parameter  int NBYTE = 4,
    localparam int AW    = $clog2(NBYTE)
) (
    input  logic [2:0]       size,
    input  logic [AW-1:0]    off,
    output logic [NBYTE-1:0] lane_en
);

    always_comb begin
        lane_en = NBYTE'(lane_mask(size, 3'(off), NBYTE));
    end

endmodule

// File: rtl/ahb_rdata_aligner.sv
// ----------------------------------------------------------------------------
// ahb_rdata_aligner
// Captures each accepted AHB address phase and, during the matching read data
// phase, passes only the addressed byte lanes of slv_hrdata through to
// mst_hrdata (other lanes zero). Also flags illegal transfers and counts
// completed ERROR responses.
//   cpu_clk       : clock
//   pad_cpu_rst_b : synchronous active-low reset
//   bus           : ahb_rdata_aligner_if.slave bundle (see interface header)
// ----------------------------------------------------------------------------
module ahb_rdata_aligner
    import ahb_align_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                 cpu_clk,
    input  logic                 pad_cpu_rst_b,
    ahb_rdata_aligner_if.slave   bus
);

    localparam int NBYTE = DATA_W / 8;
    localparam int AW    = $clog2(NBYTE);

    logic          valid_q,   valid_d;
    logic          write_q,   write_d;
    logic [2:0]    size_q,    size_d;
    logic [AW-1:0] addr_q,    addr_d;
    logic          endian_q,  endian_d;
    logic [15:0]   err_cnt_q, err_cnt_d;

    logic          accept;
    logic          err_done;
    logic [7:0]    xfer_bytes;
    logic [7:0]    off_full;
    logic          illegal;
    logic [AW-1:0] lane_off;
    logic          fwd;
    logic [NBYTE-1:0] lane_en;

    // NONSEQ and SEQ both have HTRANS[1] set.
    assign accept   = bus.mst_htrans[1] & bus.slv_hready;
    assign err_done = valid_q & bus.slv_hresp & bus.slv_hready;

    always_comb begin
        valid_d   = valid_q;
        write_d   = write_q;
        size_d    = size_q;
        addr_d    = addr_q;
        endian_d  = endian_q;
        err_cnt_d = err_cnt_q;
        if (bus.slv_hready) begin
            valid_d = accept;
            if (accept) begin
                write_d  = bus.mst_hwrite;
                size_d   = bus.mst_hsize;
                addr_d   = bus.mst_haddr;
                endian_d = bus.pad_biu_bigend_b;
            end
        end
        if (err_done && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (!pad_cpu_rst_b) begin
            valid_q   <= 1'b0;
            write_q   <= 1'b0;
            size_q    <= HSIZE_WORD;
            addr_q    <= '0;
            endian_q  <= 1'b1;
            err_cnt_q <= 16'd0;
        end else begin
            valid_q   <= valid_d;
            write_q   <= write_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            endian_q  <= endian_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Legality and lane offset of the transfer in its data phase. The offset
    // is meaningless for illegal transfers, which never forward data.
    always_comb begin
        xfer_bytes = 8'd1 << size_q;
        illegal    = (xfer_bytes > 8'(NBYTE)) ||
                     ((8'(addr_q) & (xfer_bytes - 8'd1)) != 8'd0);
        off_full   = endian_q ? 8'(addr_q)
                              : 8'(NBYTE) - xfer_bytes - 8'(addr_q);
        lane_off   = AW'(off_full);
    end

    ahb_lane_mask #(
        .NBYTE (NBYTE)
    ) u_lane_mask (
        .size    (size_q),
        .off     (lane_off),
        .lane_en (lane_en)
    );

    assign bus.rd_pend  = valid_q & ~write_q;
    assign bus.size_err = valid_q & illegal;
    assign bus.err_cnt  = err_cnt_q;

    assign fwd = valid_q & ~write_q & ~illegal & ~bus.slv_hresp;

    // Data path is purely combinational from slv_hrdata: no added latency.
    for (genvar gi = 0; gi < NBYTE; gi++) begin : g_lane
        assign bus.mst_hrdata[gi*8 +: 8] = (fwd & lane_en[gi]) ? bus.slv_hrdata[gi*8 +: 8]
                                                               : 8'h00;
    end

endmodule

// File: tb/tb_ahb_rdata_aligner.sv
// ----------------------------------------------------------------------------
// tb_ahb_rdata_aligner
// Drives identical stimulus into a 32-bit and a 64-bit aligner. Each accepted
// address phase pushes an expected data-phase record per bus width; the
// record is examined during the data phase and popped when it completes.
// ----------------------------------------------------------------------------
module tb_ahb_rdata_aligner;
    import ahb_align_pkg::*;

    logic cpu_clk       = 1'b0;
    logic pad_cpu_rst_b = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    ahb_rdata_aligner_if #(.DATA_W(32)) bus32 ();
    ahb_rdata_aligner_if #(.DATA_W(64)) bus64 ();

    ahb_rdata_aligner #(.DATA_W(32)) dut32 (
        .cpu_clk       (cpu_clk),
        .pad_cpu_rst_b (pad_cpu_rst_b),
        .bus           (bus32.slave)
    );

    ahb_rdata_aligner #(.DATA_W(64)) dut64 (
        .cpu_clk       (cpu_clk),
        .pad_cpu_rst_b (pad_cpu_rst_b),
        .bus           (bus64.slave)
    );

    typedef struct packed {
        logic        rd;
        logic        ill;
        logic [63:0] msk;
    } exp_t;

    exp_t        q32[$];
    exp_t        q64[$];
    logic [15:0] exp_err = 16'd0;
    int          checks   = 0;
    int          failures = 0;
    bit          verbose  = 1'b1;

    logic [31:0] last_d32;
    logic [63:0] last_d64;
    logic        last_rp32, last_se32, last_se64;
    logic [15:0] last_err32, last_err64;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input int nbyte, input logic write, input logic [2:0] size,
                                input logic [2:0] addr, input logic bigend_b);
        exp_t r;
        int   bytes, a, off;
        bytes = 1 << size;
        a     = int'(addr) % nbyte;
        r     = '0;
        r.rd  = !write;
        r.ill = (bytes > nbyte) || ((a % bytes) != 0);
        if (!r.ill) begin
            off = bigend_b ? a : nbyte - bytes - a;
            for (int b = 0; b < bytes; b++) r.msk[8*(off+b) +: 8] = 8'hFF;
        end
        return r;
    endfunction

    task automatic drive(input logic [1:0] trans, input logic write, input logic [2:0] size,
                         input logic [2:0] addr, input logic bigend_b, input logic hready,
                         input logic hresp, input logic [63:0] hrdata);
        bus32.mst_htrans = trans;    bus64.mst_htrans = trans;
        bus32.mst_hwrite = write;    bus64.mst_hwrite = write;
        bus32.mst_hsize  = size;     bus64.mst_hsize  = size;
        bus32.mst_haddr  = addr[1:0]; bus64.mst_haddr = addr;
        bus32.pad_biu_bigend_b = bigend_b; bus64.pad_biu_bigend_b = bigend_b;
        bus32.slv_hready = hready;   bus64.slv_hready = hready;
        bus32.slv_hresp  = hresp;    bus64.slv_hresp  = hresp;
        bus32.slv_hrdata = hrdata[31:0];
        bus64.slv_hrdata = hrdata;
    endtask

    // One bus cycle: drive at the falling edge, check outputs before the next
    // rising edge, then advance the scoreboard to the post-edge state.
    task automatic cycle(input logic [1:0] trans, input logic write, input logic [2:0] size,
                         input logic [2:0] addr, input logic bigend_b, input logic hready,
                         input logic hresp, input logic [63:0] hrdata);
        exp_t        e32, e64;
        bit          a32, a64;
        logic [63:0] d32, d64;
        @(negedge cpu_clk);
        drive(trans, write, size, addr, bigend_b, hready, hresp, hrdata);
        #1;
        a32 = q32.size() > 0;
        a64 = q64.size() > 0;
        e32 = a32 ? q32[0] : '0;
        e64 = a64 ? q64[0] : '0;
        d32 = (a32 && e32.rd && !e32.ill && !hresp) ? (hrdata & e32.msk & 64'hFFFF_FFFF) : 64'd0;
        d64 = (a64 && e64.rd && !e64.ill && !hresp) ? (hrdata & e64.msk) : 64'd0;
        check_eq("rd_pend32",  64'(bus32.rd_pend),    64'(a32 && e32.rd));
        check_eq("size_err32", 64'(bus32.size_err),   64'(a32 && e32.ill));
        check_eq("hrdata32",   64'(bus32.mst_hrdata), d32);
        check_eq("err_cnt32",  64'(bus32.err_cnt),    64'(exp_err));
        check_eq("rd_pend64",  64'(bus64.rd_pend),    64'(a64 && e64.rd));
        check_eq("size_err64", 64'(bus64.size_err),   64'(a64 && e64.ill));
        check_eq("hrdata64",   bus64.mst_hrdata,      d64);
        check_eq("err_cnt64",  64'(bus64.err_cnt),    64'(exp_err));
        last_d32   = bus32.mst_hrdata;
        last_d64   = bus64.mst_hrdata;
        last_rp32  = bus32.rd_pend;
        last_se32  = bus32.size_err;
        last_se64  = bus64.size_err;
        last_err32 = bus32.err_cnt;
        last_err64 = bus64.err_cnt;
        if (hready) begin
            if (a32) begin
                if (verbose)
                    $display("txn rd=%0b ill32=%0b ill64=%0b resp=%0b d32=%h d64=%h err=%0d",
                             e32.rd, e32.ill, e64.ill, hresp, bus32.mst_hrdata,
                             bus64.mst_hrdata, exp_err);
                if (hresp && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
                void'(q32.pop_front());
                void'(q64.pop_front());
            end
            if (trans[1]) begin
                q32.push_back(mk(4, write, size, addr, bigend_b));
                q64.push_back(mk(8, write, size, addr, bigend_b));
            end
        end
    endtask

    task automatic do_reset(input logic [63:0] hrdata);
        @(negedge cpu_clk);
        pad_cpu_rst_b = 1'b0;
        drive(HTRANS_IDLE, 1'b0, HSIZE_WORD, 3'd0, 1'b1, 1'b1, 1'b1, hrdata);
        @(negedge cpu_clk);
        #1;
        check_eq("rst_rd_pend32",  64'(bus32.rd_pend),    64'd0);
        check_eq("rst_size_err32", 64'(bus32.size_err),   64'd0);
        check_eq("rst_hrdata32",   64'(bus32.mst_hrdata), 64'd0);
        check_eq("rst_err_cnt32",  64'(bus32.err_cnt),    64'd0);
        check_eq("rst_rd_pend64",  64'(bus64.rd_pend),    64'd0);
        check_eq("rst_hrdata64",   bus64.mst_hrdata,      64'd0);
        check_eq("rst_err_cnt64",  64'(bus64.err_cnt),    64'd0);
        q32.delete();
        q64.delete();
        exp_err = 16'd0;
        pad_cpu_rst_b = 1'b1;
    endtask

    initial begin
        drive(HTRANS_IDLE, 1'b0, HSIZE_WORD, 3'd0, 1'b1, 1'b1, 1'b0, 64'd0);
        do_reset(64'hFFFF_FFFF_FFFF_FFFF);

        // Byte read, little-endian, addr 2.
        cycle(HTRANS_NONSEQ, 1'b0, HSIZE_BYTE, 3'd2, 1'b1, 1'b1, 1'b0, 64'd0);
        cycle(HTRANS_IDLE,   1'b0, HSIZE_BYTE, 3'd0, 1'b1, 1'b1, 1'b0, 64'h11223344_AABBCCDD);
        check_eq("le_byte_d32",  64'(last_d32),  64'h0000_0000_00BB_0000);
        check_eq("le_byte_rp32", 64'(last_rp32), 64'd1);
        check_eq("le_byte_d64",  last_d64,       64'h0000_0000_00BB_0000);

        // Halfword read, big-endian, addr 0.
        cycle(HTRANS_NONSEQ, 1'b0, HSIZE_HALF, 3'd0, 1'b0, 1'b1, 1'b0, 64'd0);
        cycle(HTRANS_IDLE,   1'b0, HSIZE_BYTE, 3'd0, 1'b1, 1'b1, 1'b0, 64'h11223344_55667788);
        check_eq("be_half_d64", last_d64,      64'h1122_0000_0000_0000);
        check_eq("be_half_d32", 64'(last_d32), 64'h0000_0000_5566_0000);

        // Word read with two wait states, SEQ captured on the ready cycle.
        cycle(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 3'd0, 1'b1, 1'b1, 1'b0, 64'd0);
        cycle(HTRANS_SEQ,    1'b0, HSIZE_WORD, 3'd0, 1'b1, 1'b0, 1'b0, 64'd0);
        cycle(HTRANS_SEQ,    1'b0, HSIZE_WORD, 3'd0, 1'b1, 1'b0, 1'b0, 64'd0);
        cycle(HTRANS_SEQ,    1'b0, HSIZE_WORD, 3'd0, 1'b1, 1'b1, 1'b0, 64'hCAFEF00D_DEADBEEF);
        check_eq("wait_d32", 64'(last_d32), 64'h0000_0000_DEAD_BEEF);
        cycle(HTRANS_IDLE,   1'b0, HSIZE_WORD, 3'd0, 1'b1, 1'b1, 1'b0, 64'h01234567_89ABCDEF);
        check_eq("seq_d64", last_d64, 64'h0000_0000_89AB_CDEF);

        // Misaligned word, then doubleword (too wide only on 32-bit).
        cycle(HTRANS_NONSEQ, 1'b0, HSIZE_WORD,  3'd1, 1'b1, 1'b1, 1'b0, 64'd0);
        cycle(HTRANS_NONSEQ, 1'b0, HSIZE_DWORD, 3'd0, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("misalign_se32", 64'(last_se32), 64'd1);
        check_eq("misalign_d32",  64'(last_d32),  64'd0);
        cycle(HTRANS_IDLE,   1'b0, HSIZE_BYTE,  3'd0, 1'b1, 1'b1, 1'b0, 64'h0102030405060708);
        check_eq("dword_se32", 64'(last_se32), 64'd1);
        check_eq("dword_se64", 64'(last_se64), 64'd0);
        check_eq("dword_d64",  last_d64,       64'h0102030405060708);

        // Two-cycle ERROR on a write; back-to-back read captured with it.
        cycle(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 3'd0, 1'b1, 1'b1, 1'b0, 64'd0);
        cycle(HTRANS_IDLE,   1'b0, HSIZE_WORD, 3'd0, 1'b1, 1'b0, 1'b1, 64'd0);
        check_eq("err_first_cycle", 64'(last_err32), 64'd0);
        cycle(HTRANS_NONSEQ, 1'b0, HSIZE_BYTE, 3'd3, 1'b1, 1'b1, 1'b1, 64'd0);
        cycle(HTRANS_IDLE,   1'b0, HSIZE_BYTE, 3'd0, 1'b1, 1'b1, 1'b0, 64'hA1A2A3A4_B1B2B3B4);
        check_eq("err_one",  64'(last_err32), 64'd1);
        check_eq("b2b_d32",  64'(last_d32),   64'h0000_0000_B100_0000);

        // Drive the counter into saturation.
        verbose = 1'b0;
        for (int i = 0; i < 65536; i++)
            cycle(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 3'd0, 1'b1, 1'b1, 1'b1, 64'd0);
        cycle(HTRANS_IDLE, 1'b0, HSIZE_WORD, 3'd0, 1'b1, 1'b1, 1'b1, 64'd0);
        cycle(HTRANS_IDLE, 1'b0, HSIZE_WORD, 3'd0, 1'b1, 1'b1, 1'b0, 64'd0);
        check_eq("err_sat32", 64'(last_err32), 64'hFFFF);
        check_eq("err_sat64", 64'(last_err64), 64'hFFFF);
        verbose = 1'b1;
        cycle(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 3'd0, 1'b1, 1'b1, 1'b0, 64'd0);
        cycle(HTRANS_IDLE,   1'b0, HSIZE_WORD, 3'd0, 1'b1, 1'b1, 1'b1, 64'd0);
        cycle(HTRANS_IDLE,   1'b0, HSIZE_WORD, 3'd0, 1'b1, 1'b1, 1'b0, 64'd0);
        check_eq("err_stick", 64'(last_err32), 64'hFFFF);

        // Reset during a read wait state.
        cycle(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 3'd0, 1'b1, 1'b1, 1'b0, 64'd0);
        cycle(HTRANS_IDLE,   1'b0, HSIZE_WORD, 3'd0, 1'b1, 1'b0, 1'b0, 64'd0);
        do_reset(64'h5555_AAAA_5555_AAAA);
        cycle(HTRANS_NONSEQ, 1'b0, HSIZE_HALF, 3'd2, 1'b1, 1'b1, 1'b0, 64'd0);
        cycle(HTRANS_IDLE,   1'b0, HSIZE_HALF, 3'd0, 1'b1, 1'b1, 1'b0, 64'h0000_0000_1234_5678);
        check_eq("post_rst_d32", 64'(last_d32), 64'h0000_0000_1234_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
